// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for CPU pipeline stage registers and the hazard unit.
package cpu_pipe_pkg;

  // Occupancy of a skid-buffered stage register
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // PC and payload presented by an empty (bubble) stage
  localparam logic [31:0] PC_RST_DEF   = 32'hffff_fffc;
  localparam logic [31:0] DATA_RST_DEF = 32'h0000_0000;

  // Canonical RISC-V NOP (addi x0, x0, 0) for hazard-unit bubble insertion
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage : cpu_pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for stage performance monitoring.
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment on request, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_skid_reg.sv
// Parametrised pipeline stage register with a 2-entry skid buffer so that
// in_ready is registered. Supports flush (squash to bubble) and stall (freeze).
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned        PC_W     = PC_W_DEF,
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter logic [PC_W-1:0]    PC_RST   = PC_W'(PC_RST_DEF),
  parameter logic [DATA_W-1:0]  DATA_RST = DATA_W'(DATA_RST_DEF),
  parameter int unsigned        CNT_W    = CNT_W_DEF
) (
  input  logic              clk_cpu,
  input  logic              rst_cpu_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stall
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
  output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

  // Reject degenerate widths at elaboration
  if (PC_W == 0 || DATA_W == 0 || CNT_W == 0) begin : g_bad_param
    $error("pipe_skid_reg: PC_W, DATA_W and CNT_W must be non-zero");
  end

  pipe_state_t       state_q, state_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic              acc_c;
  logic              rel_c;

  // Handshake qualifiers: flush blocks intake, stall blocks both sides
  assign acc_c = in_valid & in_ready_q & ~stall & ~flush;
  assign rel_c = out_valid_q & out_ready & ~stall;

  // Next-state and storage update; the main entry is forced to bubble values
  // whenever it becomes empty so stale data never reaches the outputs
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = EMPTY;
      main_pc_d   = PC_RST;
      main_data_d = DATA_RST;
      skid_pc_d   = PC_RST;
      skid_data_d = DATA_RST;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc_c) begin
            state_d     = FULL;
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end
        end
        FULL: begin
          if (acc_c && !rel_c) begin
            state_d     = SKID;
            skid_pc_d   = in_pc;
            skid_data_d = in_data;
          end else if (!acc_c && rel_c) begin
            state_d     = EMPTY;
            main_pc_d   = PC_RST;
            main_data_d = DATA_RST;
          end else if (acc_c && rel_c) begin
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end
        end
        SKID: begin
          if (rel_c) begin
            state_d     = FULL;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
            skid_pc_d   = PC_RST;
            skid_data_d = DATA_RST;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_pc_d   = PC_RST;
          main_data_d = DATA_RST;
          skid_pc_d   = PC_RST;
          skid_data_d = DATA_RST;
        end
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != SKID);
  end

  // State and storage registers
  always_ff @(posedge clk_cpu or negedge rst_cpu_n) begin
    if (!rst_cpu_n) begin
      state_q     <= EMPTY;
      main_pc_q   <= PC_RST;
      main_data_q <= DATA_RST;
      skid_pc_q   <= PC_RST;
      skid_data_q <= DATA_RST;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_pc_q;
  assign out_data  = main_data_q;

`ifdef PIPE_PERF_CNT_EN
  // Stall-cycle counter
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_cpu),
    .rst_n_i (rst_cpu_n),
    .inc_i   (stall),
    .cnt_o   (perf_stall_cnt)
  );

  // Flush-cycle counter
  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_cpu),
    .rst_n_i (rst_cpu_n),
    .inc_i   (flush),
    .cnt_o   (perf_flush_cnt)
  );

  // Bubble counter: downstream ready but nothing offered
  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_cpu),
    .rst_n_i (rst_cpu_n),
    .inc_i   (~out_valid_q & out_ready),
    .cnt_o   (perf_bubble_cnt)
  );
`endif

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: the driver queues expected entries on
// accept, a monitor pops and compares on every downstream release.
module tb_pipe_skid_reg;

  localparam logic [31:0] BUB_PC   = 32'hffff_fffc;
  localparam logic [31:0] BUB_DATA = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk_cpu   = 1'b0;
  logic        rst_cpu_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc     = '0;
  logic [31:0] in_data   = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        flush     = 1'b0;
  logic        stall     = 1'b0;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rel_cnt = 0;
  bit   mon_en = 1'b0;
  ent_t exp_q[$];
  int   rel_cyc[$];
  int   acc_cyc[$];
  ent_t mon_e;

`ifdef PIPE_PERF_CNT_EN
  logic [3:0] perf_stall_cnt;
  logic [3:0] perf_flush_cnt;
  logic [3:0] perf_bubble_cnt;

  pipe_skid_reg #(.CNT_W(4)) dut (
    .clk_cpu         (clk_cpu),
    .rst_cpu_n       (rst_cpu_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_data        (out_data),
    .flush           (flush),
    .stall           (stall),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );
`else
  pipe_skid_reg dut (
    .clk_cpu   (clk_cpu),
    .rst_cpu_n (rst_cpu_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .flush     (flush),
    .stall     (stall)
  );
`endif

  always #5 clk_cpu = ~clk_cpu;

  always @(posedge clk_cpu) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_cpu);
      #1;
    end
  endtask

  // Offer one entry and hold it until accepted; queue it as expected output
  task automatic push(input logic [31:0] pc, input logic [31:0] data);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_data  = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_cpu);
      if (in_ready && !stall && !flush) begin
        exp_q.push_back('{pc: pc, data: data});
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk_cpu);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept of pc %h", pc);
    end
  endtask

  // Monitor: compare every release against the scoreboard, check bubbles
  always @(negedge clk_cpu) begin
    if (rst_cpu_n && mon_en) begin
      if (out_valid && out_ready && !stall) begin
        rel_cnt++;
        rel_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_out: got pc=%h data=%h want no output", out_pc, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_pc", 64'(out_pc), 64'(mon_e.pc));
          chk("out_data", 64'(out_data), 64'(mon_e.data));
        end
      end
      if (!out_valid) begin
        chk("bubble_pc", 64'(out_pc), 64'(BUB_PC));
        chk("bubble_data", 64'(out_data), 64'(BUB_DATA));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rel0;

    // Reset values
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'(BUB_PC));
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_cpu_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    rel_cyc.delete();
    acc_cyc.delete();
    push(32'h0000_0000, 32'h0050_0093);
    push(32'h0000_0004, 32'h00a0_0113);
    push(32'h0000_0008, 32'h0020_81b3);
    tick(3);
    chk("stream_count", 64'(rel_cyc.size()), 64'd3);
    if (rel_cyc.size() == 3 && acc_cyc.size() == 3) begin
      chk("stream_latency", 64'(rel_cyc[0] - acc_cyc[0]), 64'd1);
      chk("stream_gap0", 64'(rel_cyc[1] - rel_cyc[0]), 64'd1);
      chk("stream_gap1", 64'(rel_cyc[2] - rel_cyc[1]), 64'd1);
    end

    // Backpressure fills main and skid, then drains in order
    out_ready = 1'b0;
    push(32'h0000_0010, 32'hd000_0010);
    push(32'h0000_0014, 32'hd000_0014);
    in_valid = 1'b1;
    in_pc    = 32'h0000_0018;
    in_data  = 32'hd000_0018;
    @(negedge clk_cpu);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_pc", 64'(out_pc), 64'h10);
    @(posedge clk_cpu);
    #1;
    out_ready = 1'b1;
    push(32'h0000_0018, 32'hd000_0018);
    tick(3);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Stall freezes a FULL stage and blocks intake
    out_ready = 1'b0;
    push(32'h0000_0020, 32'hd000_0020);
    rel0      = rel_cnt;
    stall     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_0024;
    in_data   = 32'hd000_0024;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_cpu);
      chk("stall_out_pc", 64'(out_pc), 64'h20);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk_cpu);
      #1;
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    tick(3);
    chk("stall_once", 64'(rel_cnt - rel0), 64'd1);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Flush in SKID with a live input discards everything
    out_ready = 1'b0;
    push(32'h0000_0030, 32'hd000_0030);
    push(32'h0000_0034, 32'hd000_0034);
    exp_q.delete();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h0000_0040;
    in_data  = 32'hd000_0040;
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk_cpu);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk_cpu);
    #1;
    out_ready = 1'b1;
    rel0 = rel_cnt;
    tick(3);
    chk("flush_no_emit", 64'(rel_cnt - rel0), 64'd0);

    // Flush in EMPTY drops a presented input
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h0000_0044;
    in_data  = 32'hd000_0044;
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick(3);
    chk("flush_empty_no_emit", 64'(rel_cnt - rel0), 64'd0);

    // Flush coinciding with a release: that entry is still delivered
    out_ready = 1'b0;
    push(32'h0000_0050, 32'hd000_0050);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk_cpu);
    chk("flush_rel_out_valid", 64'(out_valid), 64'd0);
    chk("flush_rel_consumed", 64'(exp_q.size()), 64'd0);
    @(posedge clk_cpu);
    #1;

    // Asynchronous reset mid-stream with both entries held
    out_ready = 1'b0;
    push(32'h0000_0060, 32'hd000_0060);
    push(32'h0000_0064, 32'hd000_0064);
    #2;
    rst_cpu_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_pc", 64'(out_pc), 64'(BUB_PC));
    chk("mrst_out_data", 64'(out_data), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk_cpu);
    rst_cpu_n = 1'b1;
    @(posedge clk_cpu);
    #1;

`ifdef PIPE_PERF_CNT_EN
    // Saturating perf counters from a fresh reset
    chk("perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
    chk("perf_flush_rst", 64'(perf_flush_cnt), 64'd0);
    stall = 1'b1;
    tick(20);
    stall = 1'b0;
    chk("perf_stall_sat", 64'(perf_stall_cnt), 64'hf);
    chk("perf_bubble_idle", 64'(perf_bubble_cnt), 64'd0);
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    chk("perf_bubble_3", 64'(perf_bubble_cnt), 64'd3);
`endif

    // Nothing held before reset may ever appear
    out_ready = 1'b1;
    rel0 = rel_cnt;
    tick(5);
    chk("post_rst_no_emit", 64'(rel_cnt - rel0), 64'd0);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_skid_reg
